chan_write_dispatcher: RTL
==========================

// Module: chan_write_dispatcher
// PURPOSE
//   Sequences the 1-to-8 128-bit write demux in the dynamic controller. Accepts a burst command
//   (target channel, beat count) from upstream, then streams exactly that many 128-bit beats into
//   the selected channel FIFO through the demux. Stalls on that FIFO's programmable-full flag.
//   Sits between the command/data front end and the demux + 8 channel FIFOs.
// PARAMETERS
//   NUM_CH       8     number of channels; address width = 3, fixed by the demux
//   DATA_W       128   beat width
//   LEN_W        8     burst-length field width; max burst = 2^LEN_W-1 beats
//   STALL_LIMIT  1024  consecutive full-stall cycles before stall_err is set
// PORTS
//   clk         in   1        rising-edge clock
//   rst         in   1        synchronous, active-high reset
//   cmd_valid   in   1        burst command valid
//   cmd_chan    in   3        target channel 0..7
//   cmd_len     in   LEN_W    beats in burst; 0 = illegal
//   cmd_ready   out  1        command accepted when cmd_valid&cmd_ready
//   data_valid  in   1        upstream beat valid
//   data_in     in   DATA_W   upstream beat
//   data_ready  out  1        beat accepted when data_valid&data_ready
//   fifo_pfull  in   NUM_CH   per-channel programmable-full (>=2 entries of margin)
//   address     out  3        demux select (registered)
//   wr_en       out  1        demux write enable (registered)
//   din         out  DATA_W   demux data (registered)
//   burst_done  out  1        1-cycle pulse: last beat of burst written
//   cmd_err     out  1        1-cycle pulse: cmd_len==0 command dropped
//   stall_err   out  1        sticky; cleared only by rst
//   busy        out  1        state != IDLE
// BEHAVIOUR
//   Reset: state=IDLE; address=0, wr_en=0, din=0, burst_done=0, cmd_err=0, stall_err=0,
//     remaining count=0, stall counter=0. Reset mid-burst abandons the burst; no further wr_en.
//   FSM states: IDLE, BURST.
//   - IDLE: cmd_ready=1, data_ready=0.
//     - On cmd_valid with cmd_len!=0: latch chan/len, go BURST.
//     - On cmd_len==0: pulse cmd_err next cycle, stay IDLE.
//   - BURST: cmd_ready=0; data_ready = !fifo_pfull[cur_chan] (combinational).
//     - Accepted beat: next cycle wr_en=1, address=cur_chan, din=data_in; remaining decrements.
//     - Acceptance of the final beat (remaining==1): go IDLE; burst_done pulses together with
//       that beat's wr_en.
//   - Latency: data handshake -> wr_en is exactly 1 cycle. Back-to-back beats give wr_en every
//     cycle. A new command is accepted the cycle after returning to IDLE, so min gap between
//     bursts is 1 cycle with wr_en=0.
//   - wr_en=0 cycles: address and din hold their last values (demux zeroes unselected outputs).
//   - Stall counter: increments each BURST cycle with data_valid=1 and fifo_pfull[cur_chan]=1.
//     Clears on any accepted beat or in IDLE. Reaching STALL_LIMIT sets stall_err. The burst
//     continues; it is not aborted.
//   - fifo_pfull of non-selected channels is ignored.
//   - Changes to cmd_* during BURST are ignored.
//   - Remaining-count arithmetic is LEN_W bits unsigned and never underflows: it only
//     decrements when it is >=1.
// STRUCTURE
//   - Shared include dyn_ctrl_defs.vh: NUM_CH, DATA_W, CH_ADDR_W=3, state encodings
//     S_IDLE/S_BURST.
//   - Single flat module; no sub-module required (stall timer is one counter inline).
// TESTING
//   1. rst, then cmd chan=3 len=4, data every cycle, pfull=0 -> 4 wr_en cycles, address=3,
//      din matches inputs in order, burst_done on the 4th, busy falls.
//   2. cmd chan=5 len=3; pfull[5]=1 for 5 cycles after beat 1 -> data_ready=0 throughout the
//      stall, exactly 3 writes total, no beat lost or duplicated.
//   3. cmd len=0 -> cmd_err pulse, no wr_en, cmd_ready stays 1; next cmd chan=0 len=1 proceeds
//      normally.
//   4. STALL_LIMIT=16, chan=7 held pfull -> stall_err=1 after 16 stalled cycles; release pfull ->
//      burst completes, stall_err stays 1 until rst.
//   5. rst asserted after 2 of 6 beats on chan=2 -> next cycle wr_en=0, busy=0, all outputs at
//      reset values.
//   6. Back-to-back cmds chan=1 len=2 then chan=6 len=2 -> writes at addr 1,1 then 6,6; one idle
//      wr_en cycle between; pfull[1]=1 during burst 2 has no effect.

Source files
------------

// File: rtl/chan_write_dispatcher_pkg.sv
// Shared widths and state encoding for the channel write dispatcher.
// The channel address width is fixed by the 1-to-8 demux it drives.
package chan_write_dispatcher_pkg;
    localparam int NUM_CH    = 8;
    localparam int CH_ADDR_W = 3;
    localparam int DATA_W    = 128;
    localparam int LEN_W     = 8;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;
endpackage

// File: rtl/chan_write_dispatcher.sv
// Takes a (channel, length) burst command, then streams that many beats into the
// selected channel FIFO through the write demux, stalling on that FIFO's pfull.
module chan_write_dispatcher
    import chan_write_dispatcher_pkg::*;
#(
    parameter int STALL_LIMIT = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cmd_valid,
    input  logic [CH_ADDR_W-1:0] i_cmd_chan,
    input  logic [LEN_W-1:0]     i_cmd_len,
    output logic                 o_cmd_ready,
    input  logic                 i_data_valid,
    input  logic [DATA_W-1:0]    i_data_in,
    output logic                 o_data_ready,
    input  logic [NUM_CH-1:0]    i_fifo_pfull,
    output logic [CH_ADDR_W-1:0] o_address,
    output logic                 o_wr_en,
    output logic [DATA_W-1:0]    o_din,
    output logic                 o_burst_done,
    output logic                 o_cmd_err,
    output logic                 o_stall_err,
    output logic                 o_busy
);
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    state_t               r_state, w_state_nxt;
    logic [CH_ADDR_W-1:0] r_chan;
    logic [LEN_W-1:0]     r_remaining;
    logic [STALL_W-1:0]   r_stall_cnt;
    logic [CH_ADDR_W-1:0] r_address;
    logic [DATA_W-1:0]    r_din;
    logic                 r_wr_en, r_burst_done, r_cmd_err, r_stall_err;
    logic                 w_cmd_acc, w_cmd_bad, w_beat_acc, w_last_beat, w_stalled;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        o_cmd_ready  = 1'b0;
        o_data_ready = 1'b0;
        w_cmd_acc    = 1'b0;
        w_cmd_bad    = 1'b0;
        w_beat_acc   = 1'b0;
        w_last_beat  = 1'b0;
        w_stalled    = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_cmd_ready = 1'b1;
                w_cmd_acc   = i_cmd_valid && (i_cmd_len != '0);
                w_cmd_bad   = i_cmd_valid && (i_cmd_len == '0);
                if (w_cmd_acc) w_state_nxt = S_BURST;
            end
            S_BURST: begin
                // Only the selected channel's pfull can hold off the stream.
                o_data_ready = !i_fifo_pfull[r_chan];
                w_beat_acc   = i_data_valid && o_data_ready;
                w_stalled    = i_data_valid && i_fifo_pfull[r_chan];
                w_last_beat  = w_beat_acc && (r_remaining == LEN_W'(1));
                if (w_last_beat) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_chan       <= '0;
            r_remaining  <= '0;
            r_stall_cnt  <= '0;
            r_address    <= '0;
            r_din        <= '0;
            r_wr_en      <= 1'b0;
            r_burst_done <= 1'b0;
            r_cmd_err    <= 1'b0;
            r_stall_err  <= 1'b0;
        end else begin
            r_wr_en      <= w_beat_acc;
            r_burst_done <= w_last_beat;
            r_cmd_err    <= w_cmd_bad;
            if (w_cmd_acc) begin
                r_chan      <= i_cmd_chan;
                r_remaining <= i_cmd_len;
            end
            // Address/data hold on idle cycles; the demux masks them via wr_en.
            if (w_beat_acc) begin
                r_address <= r_chan;
                r_din     <= i_data_in;
                if (r_remaining != '0) r_remaining <= r_remaining - LEN_W'(1);
            end
            if (r_state != S_BURST || w_beat_acc) begin
                r_stall_cnt <= '0;
            end else if (w_stalled && r_stall_cnt != STALL_W'(STALL_LIMIT)) begin
                r_stall_cnt <= r_stall_cnt + STALL_W'(1);
                if (r_stall_cnt == STALL_W'(STALL_LIMIT - 1)) r_stall_err <= 1'b1;
            end
        end
    end

    assign o_address    = r_address;
    assign o_wr_en      = r_wr_en;
    assign o_din        = r_din;
    assign o_burst_done = r_burst_done;
    assign o_cmd_err    = r_cmd_err;
    assign o_stall_err  = r_stall_err;
    assign o_busy       = (r_state != S_IDLE);
endmodule
